seg7_scan_n: RTL

- Parametrised N-digit multiplexed seven-segment display scanner. Next generation of the fixed 4-digit Basys2 display path used by alarm_clock.
- Adds: configurable digit count, per-digit blink, leading-zero blanking, PWM brightness, and frame-coherent input snapshot.
- Sits between the time/alarm datapath and the board pins seg/an/dp. All outputs are active-low.

---
 rtl/seg7_scan_n.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_n.sv
// N-digit multiplexed seven-segment scanner with per-digit blink, leading-zero
// blanking, PWM brightness and a per-frame input snapshot. All outputs active-low.
module seg7_scan_n #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 250,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    MCLK,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int OL_W  = BRIGHT_W + PS_W + 2;

  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(BLINK_DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [PS_W-1:0]         prescale_q, prescale_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BC_W-1:0]         blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic                    sh_lz_q, sh_lz_d;
  logic [BRIGHT_W-1:0]     sh_bright_q, sh_bright_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q, frame_start_d;

  logic            slot_tick, frame_wrap, blink_wrap, load;
  logic            lz_nonzero, blank;
  logic [OL_W-1:0] on_len;

  always_comb begin
    slot_tick  = (prescale_q == PS_MAX);
    frame_wrap = slot_tick && (idx_q == IDX_MAX);
    blink_wrap = frame_wrap && (blink_cnt_q == BC_MAX);
    load       = (prescale_q == '0) && (idx_q == '0);

    prescale_d    = slot_tick ? '0 : prescale_q + PS_W'(1);
    idx_d         = idx_q;
    if (slot_tick)
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    blink_cnt_d   = blink_cnt_q;
    if (frame_wrap)
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BC_W'(1);
    blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;

    // The load cycle already displays the freshly captured values, so the
    // whole frame (its first cycle included) is drawn from one snapshot.
    sh_digits_d = load ? digits     : sh_digits_q;
    sh_dp_d     = load ? dp_in      : sh_dp_q;
    sh_blink_d  = load ? blink_mask : sh_blink_q;
    sh_lz_d     = load ? lz_en      : sh_lz_q;
    sh_bright_d = load ? brightness : sh_bright_q;

    lz_nonzero = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx_q) && sh_digits_d[4*k +: 4] != 4'd0)
        lz_nonzero = 1'b1;
    end

    on_len = ((OL_W'(sh_bright_d) + OL_W'(1)) * OL_W'(SCAN_DIV)) >> BRIGHT_W;

    blank = 1'b0;
    if (blink_phase_q && sh_blink_d[idx_q])
      blank = 1'b1;
    if (sh_lz_d && idx_q != '0 && !lz_nonzero)
      blank = 1'b1;
    if (OL_W'(prescale_q) >= on_len)
      blank = 1'b1;

    if (blank) begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = hex7(sh_digits_d[4*idx_q +: 4]);
      dp_d  = ~sh_dp_d[idx_q];
    end
    frame_start_d = load;
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      prescale_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_digits_q   <= '0;
      sh_dp_q       <= '0;
      sh_blink_q    <= '0;
      sh_lz_q       <= 1'b0;
      sh_bright_q   <= '0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      prescale_q    <= prescale_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_digits_q   <= sh_digits_d;
      sh_dp_q       <= sh_dp_d;
      sh_blink_q    <= sh_blink_d;
      sh_lz_q       <= sh_lz_d;
      sh_bright_q   <= sh_bright_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule
